phase_sequencer: RTL and testbench

Instruction-phase state machine for the controller. It produces the one-hot phase strobes (IF0 … MUL4) that feed the ISR/decoder stage, and takes that stage's instruction-class outputs back to choose the next phase. It inserts memory wait states, runs the 16-iteration multiply loop, and enters the interrupt sequence between instructions.

---
 rtl/phase_sequencer_pkg.sv | 37 +++
 rtl/phase_sequencer_mul_counter.sv | 31 +++
 rtl/phase_sequencer.sv | 149 ++++++++++++++
 tb/tb_phase_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared controller definitions: one-hot phase bit positions, phase vector type,
// multiply iteration default. Also imported by the ISR/decoder stage.
package phase_sequencer_pkg;

  localparam int NUM_PH = 17;

  localparam int PH_IF0   = 0;
  localparam int PH_IF1   = 1;
  localparam int PH_FF0   = 2;
  localparam int PH_FF1   = 3;
  localparam int PH_FF2   = 4;
  localparam int PH_TF0   = 5;
  localparam int PH_TF1   = 6;
  localparam int PH_EX0   = 7;
  localparam int PH_EX1   = 8;
  localparam int PH_IT0   = 9;
  localparam int PH_IT1   = 10;
  localparam int PH_IT2   = 11;
  localparam int PH_MUL1  = 12;
  localparam int PH_MUL21 = 13;
  localparam int PH_MUL22 = 14;
  localparam int PH_MUL3  = 15;
  localparam int PH_MUL4  = 16;

  typedef logic [NUM_PH-1:0] phase_vec_t;

  localparam int MUL_ITER_DEF = 16;

  function automatic phase_vec_t ph(input int idx);
    return phase_vec_t'(1) << idx;
  endfunction

  function automatic logic is_onehot(input phase_vec_t v);
    return (v != '0) && ((v & (v - phase_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/phase_sequencer_mul_counter.sv
// Multiply iteration counter: increment, clear and terminal-count flag.
// The 4-bit count wraps to 0 after the 16th increment when MUL_ITER=16.
module phase_mul_counter #(
  parameter int MUL_ITER = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       last
);

  logic [3:0] cnt_q, cnt_d;

  // last: the increment about to happen completes the final iteration
  assign last = ({1'b0, cnt_q} == 5'(MUL_ITER - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: one-hot phase strobes, wait states, multiply loop,
// interrupt entry. Define PHASE_SEQ_WAIT_EN to honour MEM_RDY hold behaviour.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int MUL_ITER = MUL_ITER_DEF
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       MEM_RDY,
  input  logic       f_is_D,
  input  logic       t_is_D,
  input  logic       op_MUL,
  input  logic       op_SVC,
  input  logic       op_RIT,
  input  logic       EIT_gate,
  input  logic       OIT_gate,
  output logic       IF0,
  output logic       IF1,
  output logic       FF0,
  output logic       FF1,
  output logic       FF2,
  output logic       TF0,
  output logic       TF1,
  output logic       EX0,
  output logic       EX1,
  output logic       IT0,
  output logic       IT1,
  output logic       IT2,
  output logic       MUL1,
  output logic       MUL2_1,
  output logic       MUL2_2,
  output logic       MUL3,
  output logic       MUL4,
  output logic [3:0] MUL_CNT,
  output logic       IT_SRC,
  output logic       INST_END
);

  logic mem_rdy;
`ifdef PHASE_SEQ_WAIT_EN
  assign mem_rdy = MEM_RDY;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = MEM_RDY;
  assign mem_rdy        = 1'b1;
`endif

  phase_vec_t phase_q, phase_d;
  logic       it_src_q, it_src_d;
  logic       inst_end_q, inst_end_d;
  logic       cnt_inc, cnt_clr, cnt_last, end_now;

  phase_mul_counter #(.MUL_ITER(MUL_ITER)) u_mul_cnt (
    .clk  (CLK),
    .clr_n(CLR),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .cnt  (MUL_CNT),
    .last (cnt_last)
  );

  always_comb begin
    phase_d  = phase_q;
    it_src_d = it_src_q;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    // cycle on which the current instruction finishes
    end_now  = (phase_q[PH_EX0] & t_is_D) | (phase_q[PH_EX1] & mem_rdy) | phase_q[PH_MUL4];

    if (!is_onehot(phase_q)) begin
      phase_d = ph(PH_IF0);
      cnt_clr = 1'b1;
    end else if (end_now) begin
      cnt_clr = phase_q[PH_MUL4];
      if (EIT_gate | OIT_gate) begin
        phase_d  = ph(PH_IT0);
        it_src_d = EIT_gate;
      end else begin
        phase_d  = ph(PH_IF0);
      end
    end else begin
      case (1'b1)
        phase_q[PH_IF0]:   if (mem_rdy) phase_d = ph(PH_IF1);
        phase_q[PH_IF1]: begin
          if (op_SVC | op_RIT) phase_d = ph(PH_IT0);
          else if (op_MUL)     phase_d = ph(PH_MUL1);
          else if (!f_is_D)    phase_d = ph(PH_FF0);
          else if (!t_is_D)    phase_d = ph(PH_TF0);
          else                 phase_d = ph(PH_EX0);
        end
        phase_q[PH_FF0]:   phase_d = ph(PH_FF1);
        phase_q[PH_FF1]:   if (mem_rdy) phase_d = ph(PH_FF2);
        phase_q[PH_FF2]:   phase_d = t_is_D ? ph(PH_EX0) : ph(PH_TF0);
        phase_q[PH_TF0]:   phase_d = ph(PH_TF1);
        phase_q[PH_TF1]:   if (mem_rdy) phase_d = ph(PH_EX0);
        phase_q[PH_EX0]:   phase_d = ph(PH_EX1);
        phase_q[PH_MUL1]:  phase_d = ph(PH_MUL21);
        phase_q[PH_MUL21]: phase_d = ph(PH_MUL22);
        phase_q[PH_MUL22]: begin
          cnt_inc = 1'b1;
          phase_d = cnt_last ? ph(PH_MUL3) : ph(PH_MUL21);
        end
        phase_q[PH_MUL3]:  phase_d = ph(PH_MUL4);
        phase_q[PH_IT0]:   phase_d = ph(PH_IT1);
        phase_q[PH_IT1]:   if (mem_rdy) phase_d = ph(PH_IT2);
        phase_q[PH_IT2]:   phase_d = ph(PH_IF0);
        default:           phase_d = phase_q;
      endcase
    end

    // INST_END pulses on the first cycle of the end phase, so it can be registered
    inst_end_d = (phase_d[PH_EX0] & t_is_D) | (phase_d[PH_EX1] & phase_q[PH_EX0]) |
                 (phase_d[PH_MUL4] & phase_q[PH_MUL3]);
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      phase_q    <= ph(PH_IF0);
      it_src_q   <= 1'b0;
      inst_end_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      it_src_q   <= it_src_d;
      inst_end_q <= inst_end_d;
    end
  end

  assign IF0      = phase_q[PH_IF0];
  assign IF1      = phase_q[PH_IF1];
  assign FF0      = phase_q[PH_FF0];
  assign FF1      = phase_q[PH_FF1];
  assign FF2      = phase_q[PH_FF2];
  assign TF0      = phase_q[PH_TF0];
  assign TF1      = phase_q[PH_TF1];
  assign EX0      = phase_q[PH_EX0];
  assign EX1      = phase_q[PH_EX1];
  assign IT0      = phase_q[PH_IT0];
  assign IT1      = phase_q[PH_IT1];
  assign IT2      = phase_q[PH_IT2];
  assign MUL1     = phase_q[PH_MUL1];
  assign MUL2_1   = phase_q[PH_MUL21];
  assign MUL2_2   = phase_q[PH_MUL22];
  assign MUL3     = phase_q[PH_MUL3];
  assign MUL4     = phase_q[PH_MUL4];
  assign IT_SRC   = it_src_q;
  assign INST_END = inst_end_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: per-cycle reference model plus literal sequence checks.
module tb_phase_sequencer;
  import phase_sequencer_pkg::*;

  localparam int ITER = 16;

  logic CLK = 1'b0;
  logic CLR, MEM_RDY, f_is_D, t_is_D, op_MUL, op_SVC, op_RIT, EIT_gate, OIT_gate;
  logic IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2;
  logic MUL1, MUL2_1, MUL2_2, MUL3, MUL4, IT_SRC, INST_END;
  logic [3:0] MUL_CNT;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  phase_sequencer #(.MUL_ITER(ITER)) dut (
    .CLK(CLK), .CLR(CLR), .MEM_RDY(MEM_RDY), .f_is_D(f_is_D), .t_is_D(t_is_D),
    .op_MUL(op_MUL), .op_SVC(op_SVC), .op_RIT(op_RIT), .EIT_gate(EIT_gate), .OIT_gate(OIT_gate),
    .IF0(IF0), .IF1(IF1), .FF0(FF0), .FF1(FF1), .FF2(FF2), .TF0(TF0), .TF1(TF1),
    .EX0(EX0), .EX1(EX1), .IT0(IT0), .IT1(IT1), .IT2(IT2),
    .MUL1(MUL1), .MUL2_1(MUL2_1), .MUL2_2(MUL2_2), .MUL3(MUL3), .MUL4(MUL4),
    .MUL_CNT(MUL_CNT), .IT_SRC(IT_SRC), .INST_END(INST_END)
  );

  function automatic logic [16:0] strobes();
    return {MUL4, MUL3, MUL2_2, MUL2_1, MUL1, IT2, IT1, IT0, EX1, EX0, TF1, TF0, FF2, FF1, FF0, IF1, IF0};
  endfunction

  function automatic int ph_of();
    logic [16:0] v;
    v = strobes();
    if (!$onehot(v)) return -1;
    for (int i = 0; i < 17; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model: phase names and iteration counts ----------------
  int m_ph = PH_IF0, m_iter = 0;
  bit m_end = 1'b0, m_src = 1'b0, model_ok = 1'b0;

  function automatic bit is_end_phase(input int p);
    return (p == PH_EX0 && t_is_D) || p == PH_EX1 || p == PH_MUL4;
  endfunction

  always @(posedge CLK) begin
    int nx;
    bit rdy, fin;
`ifdef PHASE_SEQ_WAIT_EN
    rdy = MEM_RDY;
`else
    rdy = 1'b1;
`endif
    model_ok = 1'b1;
    if (!CLR) begin
      m_ph = PH_IF0; m_iter = 0; m_end = 1'b0; m_src = 1'b0;
    end else begin
      nx  = m_ph;
      fin = 1'b0;
      case (m_ph)
        PH_IF0:   if (rdy) nx = PH_IF1;
        PH_IF1:   nx = (op_SVC || op_RIT) ? PH_IT0 : op_MUL ? PH_MUL1 :
                       !f_is_D ? PH_FF0 : !t_is_D ? PH_TF0 : PH_EX0;
        PH_FF0:   nx = PH_FF1;
        PH_FF1:   if (rdy) nx = PH_FF2;
        PH_FF2:   nx = t_is_D ? PH_EX0 : PH_TF0;
        PH_TF0:   nx = PH_TF1;
        PH_TF1:   if (rdy) nx = PH_EX0;
        PH_EX0:   if (t_is_D) fin = 1'b1; else nx = PH_EX1;
        PH_EX1:   if (rdy) fin = 1'b1;
        PH_MUL1:  nx = PH_MUL21;
        PH_MUL21: nx = PH_MUL22;
        PH_MUL22: begin m_iter++; nx = (m_iter < ITER) ? PH_MUL21 : PH_MUL3; end
        PH_MUL3:  nx = PH_MUL4;
        PH_MUL4:  begin fin = 1'b1; m_iter = 0; end
        PH_IT0:   nx = PH_IT1;
        PH_IT1:   if (rdy) nx = PH_IT2;
        PH_IT2:   nx = PH_IF0;
        default:  nx = PH_IF0;
      endcase
      if (fin) begin
        if (EIT_gate || OIT_gate) begin nx = PH_IT0; m_src = EIT_gate; end
        else nx = PH_IF0;
      end
      m_end = is_end_phase(nx) && nx != m_ph;
      m_ph  = nx;
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      chk("strobes", 32'(strobes()), 32'(1) << m_ph);
      chk("MUL_CNT", 32'(MUL_CNT), 32'(m_iter % 16));
      chk("IT_SRC", 32'(IT_SRC), 32'(m_src));
      chk("INST_END", 32'(INST_END), 32'(m_end));
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wait_ph(input int p);
    int k = 0;
    while (ph_of() != p && k < 100) begin step(); k++; end
    chk("wait_phase", 32'(ph_of()), 32'(p));
  endtask

`ifdef PHASE_SEQ_WAIT_EN
  int exp_mem[12] = '{PH_IF0, PH_IF1, PH_FF0, PH_FF1, PH_FF1, PH_FF1, PH_FF2, PH_TF0,
                      PH_TF1, PH_EX0, PH_EX1, PH_EX1};
`else
  int exp_mem[12] = '{PH_IF0, PH_IF1, PH_FF0, PH_FF1, PH_FF2, PH_TF0, PH_TF1, PH_EX0,
                      PH_EX1, PH_IF0, PH_IF1, PH_FF0};
`endif

  initial begin
    int pairs;
    CLR = 1'b0; MEM_RDY = 1'b1; f_is_D = 1'b1; t_is_D = 1'b1;
    op_MUL = 1'b0; op_SVC = 1'b0; op_RIT = 1'b0; EIT_gate = 1'b0; OIT_gate = 1'b0;

    // reset, then register-register loop IF0 IF1 EX0
    step(2);
    chk("rst_IF0", 32'(ph_of()), PH_IF0);
    chk("rst_MUL_CNT", 32'(MUL_CNT), 0);
    chk("rst_INST_END", 32'(INST_END), 0);
    CLR = 1'b1;
    step(); chk("rr_IF1", 32'(ph_of()), PH_IF1);
    step(); chk("rr_EX0", 32'(ph_of()), PH_EX0); chk("rr_end", 32'(INST_END), 1);
    step(); chk("rr_IF0", 32'(ph_of()), PH_IF0); chk("rr_end_off", 32'(INST_END), 0);
    step(3); chk("rr_IF0_again", 32'(ph_of()), PH_IF0); chk("rr_end_off2", 32'(INST_END), 0);

    // memory operands, MEM_RDY low two cycles in FF1 and one in EX1
    f_is_D = 1'b0; t_is_D = 1'b0;
    for (int i = 0; i < 12; i++) begin
      MEM_RDY = !(i == 3 || i == 4 || i == 10);
      chk($sformatf("mem_seq[%0d]", i), 32'(ph_of()), 32'(exp_mem[i]));
      step();
    end
    MEM_RDY = 1'b1; f_is_D = 1'b1; t_is_D = 1'b1;
    wait_ph(PH_IF0);

    // multiply: 16 iterations, MUL4 on cycle 37
    op_MUL = 1'b1;
    pairs  = 0;
    for (int i = 0; i < 37; i++) begin
      if (MUL2_1) pairs++;
      if (i == 2)  chk("mul_MUL1", 32'(ph_of()), PH_MUL1);
      if (i == 4)  begin chk("mul_first22", 32'(ph_of()), PH_MUL22); chk("mul_cnt0", 32'(MUL_CNT), 0); end
      if (i == 5)  begin chk("mul_second21", 32'(ph_of()), PH_MUL21); chk("mul_cnt1", 32'(MUL_CNT), 1); end
      if (i == 33) chk("mul_cnt15", 32'(MUL_CNT), 15);
      if (i == 35) chk("mul_MUL3", 32'(ph_of()), PH_MUL3);
      if (i == 36) begin chk("mul_MUL4", 32'(ph_of()), PH_MUL4); chk("mul_end", 32'(INST_END), 1); end
      if (i < 36) step();
    end
    op_MUL = 1'b0;
    chk("mul_pairs", 32'(pairs), 16);
    step(); chk("mul_after_IF0", 32'(ph_of()), PH_IF0); chk("mul_after_cnt", 32'(MUL_CNT), 0);

    // simultaneous interrupts at EX0 end phase: external wins
    EIT_gate = 1'b1; OIT_gate = 1'b1;
    step(2); chk("irq_EX0", 32'(ph_of()), PH_EX0); chk("irq_end", 32'(INST_END), 1);
    step(); chk("irq_IT0", 32'(ph_of()), PH_IT0); chk("irq_src", 32'(IT_SRC), 1);
    EIT_gate = 1'b0; OIT_gate = 1'b0;
    step(); chk("irq_IT1", 32'(ph_of()), PH_IT1);
    step(); chk("irq_IT2", 32'(ph_of()), PH_IT2);
    step(); chk("irq_IF0", 32'(ph_of()), PH_IF0);

    // SVC beats MUL in decode, IT_SRC unchanged
    op_SVC = 1'b1; op_MUL = 1'b1;
    step(2); chk("svc_IT0", 32'(ph_of()), PH_IT0); chk("svc_src", 32'(IT_SRC), 1);
    op_SVC = 1'b0; op_MUL = 1'b0;
    wait_ph(PH_IF0);

    // internal interrupt only
    OIT_gate = 1'b1;
    step(3); chk("oit_IT0", 32'(ph_of()), PH_IT0); chk("oit_src", 32'(IT_SRC), 0);
    OIT_gate = 1'b0;
    wait_ph(PH_IF0);

    // reset during MUL2_1 with MUL_CNT=5
    op_MUL = 1'b1;
    step(13);
    chk("rmul_MUL21", 32'(ph_of()), PH_MUL21); chk("rmul_cnt5", 32'(MUL_CNT), 5);
    CLR = 1'b0;
    step(); chk("rmul_IF0", 32'(ph_of()), PH_IF0); chk("rmul_cnt0", 32'(MUL_CNT), 0);
    CLR = 1'b1; op_MUL = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
